// File: rtl/spi_reconfig_responder_pkg.sv
// Shared types and helpers for the ESP32 reboot-command responder.
package spi_reconfig_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_ARM,
      ST_PULSE
   } state_e;

   localparam int unsigned CNT_W      = 5;
   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned CNT_SAT    = 17;

   // Loop-based ceiling log2, usable in constant expressions by any timer block.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      if (value > 1) begin
         v = value - 1;
         while (v > 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_reconfig_responder_if.sv
// ESP32 SPI link as seen by the FPGA: the ESP drives, the responder listens.
interface spi_reconfig_responder_if;
   logic esp_cs_n;
   logic esp_sclk;
   logic esp_mosi;

   modport master (output esp_cs_n, esp_sclk, esp_mosi);
   modport slave  (input  esp_cs_n, esp_sclk, esp_mosi);
endinterface

// File: rtl/spi_in_sync.sv
// Three-flop synchronizer with registered rise/fall strobes, all aligned to the third flop.
module spi_in_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         s3   <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
         fall <= ~s2 & s3;
      end
   end

   assign level = s3;

endmodule

// File: rtl/spi_reconfig_responder.sv
// Listens for a two-byte reboot command on the ESP32 SPI link and issues one
// timed active-low reconfiguration pulse after the frame closes.
module spi_reconfig_responder
   import spi_reconfig_responder_pkg::*;
#(
   parameter int unsigned CLOCK_MHZ = 27,
   parameter logic [7:0]  CMD_BYTE  = 8'hA5,
   parameter logic [7:0]  KEY_BYTE  = 8'h5A,
   parameter int unsigned DELAY_US  = 100,
   parameter int unsigned PULSE_US  = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   spi_reconfig_responder_if.slave  esp,
   output logic                     reconfig_n,
   output logic                     cmd_seen
);

   localparam int unsigned DELAY_CYC  = CLOCK_MHZ * DELAY_US;
   localparam int unsigned PULSE_CYC  = CLOCK_MHZ * PULSE_US;
   localparam int unsigned PULSE_LOAD = (PULSE_CYC > 0) ? PULSE_CYC - 1 : 0;
   localparam int unsigned MAX_CYC    = (DELAY_CYC > PULSE_CYC) ? DELAY_CYC : PULSE_CYC;
   // Timer is loaded with DELAY_CYC itself, so size it to hold that value.
   localparam int unsigned TIMER_W    = (clog2(MAX_CYC + 1) > 0) ? clog2(MAX_CYC + 1) : 1;
   localparam logic [15:0] CMD_WORD   = {CMD_BYTE, KEY_BYTE};

   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_rise;
   logic sclk_lvl_unused, sclk_fall_unused;
   logic mosi_m1, mosi_s;

   spi_in_sync #(.RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (esp.esp_cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_in_sync #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (esp.esp_sclk),
      .level (sclk_lvl_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall_unused)
   );

   // mosi is stable around the sclk rising edge, two flops are enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_m1 <= 1'b0;
         mosi_s  <= 1'b0;
      end else begin
         mosi_m1 <= esp.esp_mosi;
         mosi_s  <= mosi_m1;
      end
   end

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [15:0]          shift_q, shift_d;
   logic                 reconfig_n_d;
   logic                 cmd_seen_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         cnt_q      <= '0;
         shift_q    <= '0;
         reconfig_n <= 1'b1;
         cmd_seen   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         reconfig_n <= reconfig_n_d;
         cmd_seen   <= cmd_seen_d;
      end
   end

   // Frame capture, command match and the shared ARM/PULSE down-counter.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      reconfig_n_d = reconfig_n;
      cmd_seen_d   = 1'b0;

      if (cs_fall) begin
         cnt_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            // A closing cs_n wins over an sclk edge landing in the same clk.
            if (cs_rise) begin
               if ((cnt_q == CNT_W'(FRAME_BITS)) && (shift_q == CMD_WORD)) begin
                  cmd_seen_d = 1'b1;
                  timer_d    = TIMER_W'(DELAY_CYC);
                  state_d    = ST_ARM;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (sclk_rise && !cs_lvl) begin
               shift_d = {shift_q[14:0], mosi_s};
               if (cnt_q != CNT_W'(CNT_SAT)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_ARM: begin
            if (timer_q == '0) begin
               reconfig_n_d = 1'b0;
               timer_d      = TIMER_W'(PULSE_LOAD);
               state_d      = ST_PULSE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_PULSE: begin
            if (timer_q == '0) begin
               reconfig_n_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
